// File: rtl/lfsr_rng_arbiter_pkg.sv
// lfsr_rng_pkg: shared constants and types for the LFSR random-source arbiter.
//   LFSR_W       : width of the random word / LFSR state
//   DEFAULT_SEED : power-on seed, also used whenever a zero seed is offered
//   LFSR_TAPS    : feedback tap mask (bits 27,23,19,18,15,11,7,4,1)
//   CNT_W        : width of the warm-up counter (covers 0..255)
//   lfsr_next()  : one Fibonacci step, shift left with XOR feedback into bit 0
//   fsm_state_e  : WARMUP / SERVE
package lfsr_rng_pkg;

    localparam int LFSR_W = 32;
    localparam int CNT_W  = 8;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'h00BC3328;

    // One bit set per tap position: 27,23,19,18,15,11,7,4,1.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h088C8892;

    typedef enum logic {
        WARMUP = 1'b0,
        SERVE  = 1'b1
    } fsm_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_if.sv
// lfsr_rng_arbiter_if: consumer-side bundle of the shared random source.
//   req_i        : per-requester request level
//   ack_o        : one-hot grant pulse, one cycle wide
//   rand_o       : random word, valid in the cycle ack_o is high
//   seed_valid_i : single-cycle reseed strobe
//   seed_i       : reseed value
//   ready_o      : high while the source is serving (not warming up)
//
// Handshake: a requester raises req_i[k] and holds it until it sees
// ack_o[k]; that cycle rand_o carries its word. It may then drop req_i[k]
// or keep it high to ask for another word. A word is consumed exactly
// when ack_o[k] is high; there is no back-pressure on the ack side.
interface lfsr_rng_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import lfsr_rng_pkg::*;

    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] ack_o;
    logic [LFSR_W-1:0]  rand_o;
    logic               seed_valid_i;
    logic [LFSR_W-1:0]  seed_i;
    logic               ready_o;

    modport master (
        output req_i,
        output seed_valid_i,
        output seed_i,
        input  ack_o,
        input  rand_o,
        input  ready_o
    );

    modport slave (
        input  req_i,
        input  seed_valid_i,
        input  seed_i,
        output ack_o,
        output rand_o,
        output ready_o
    );

endinterface

// File: rtl/lfsr_rng_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   eligible_i   : requesters that may be granted this cycle
//   last_grant_i : index of the previous winner; the search starts one past it
//   grant_o      : one-hot winner (all zero when nothing is eligible)
//   any_grant_o  : high when grant_o has a bit set
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     grant_o,
    output logic             any_grant_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'((int'(last_grant_i) + 1 + i) % N);
            if (!found && eligible_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign any_grant_o = |eligible_i;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: one 32-bit Fibonacci LFSR shared by NUM_REQ consumers.
// Each grant hands out the current LFSR state and steps it, so every
// delivered word is unique. After reset or a reseed the LFSR is stepped
// WARMUP_CYCLES times before any grant is issued.
//   clk_i       : clock
//   reset_i     : asynchronous, active-high reset
//   bus         : slave side of lfsr_rng_arbiter_if (req/ack/rand/seed/ready)
//   dbg_state_o : current FSM state, for observation only
module lfsr_rng_arbiter
    import lfsr_rng_pkg::*;
#(
    parameter int                NUM_REQ       = 4,
    parameter int                WARMUP_CYCLES = 32,
    parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    lfsr_rng_arbiter_if.slave        bus,
    output fsm_state_e               dbg_state_o
);

    localparam int               IDX_W        = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] WARMUP_LIMIT = CNT_W'(WARMUP_CYCLES);

    fsm_state_e          state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]   rand_q, rand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [IDX_W-1:0]    last_q, last_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  winner;
    logic                any_grant;
    logic [IDX_W-1:0]    winner_idx;
    logic [LFSR_W-1:0]   lfsr_raw_next;
    logic [LFSR_W-1:0]   lfsr_stepped;
    logic [LFSR_W-1:0]   seed_load;

    // The requester acked last cycle is masked so a held request cannot
    // be granted twice in a row before it has seen its ack.
    assign eligible = bus.req_i & ~ack_q;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .eligible_i   (eligible),
        .last_grant_i (last_q),
        .grant_o      (winner),
        .any_grant_o  (any_grant)
    );

    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                winner_idx = IDX_W'(i);
            end
        end
    end

    // The tap set does not include bit 31, so the step is not a bijection:
    // 0x80000000 would map to zero. Falling back to SEED keeps the state
    // away from the all-zero lock-up value.
    assign lfsr_raw_next = lfsr_next(lfsr_q);
    assign lfsr_stepped  = (lfsr_raw_next == '0) ? SEED : lfsr_raw_next;
    assign seed_load     = (bus.seed_i == '0) ? SEED : bus.seed_i;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        rand_d  = rand_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        last_d  = last_q;

        if (bus.seed_valid_i) begin
            // Reseed wins over any grant arbitrated this cycle; that
            // requester keeps its request up and is served after warm-up.
            lfsr_d  = seed_load;
            cnt_d   = '0;
            state_d = WARMUP;
        end else begin
            unique case (state_q)
                WARMUP: begin
                    if (cnt_q < WARMUP_LIMIT) begin
                        lfsr_d = lfsr_stepped;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = SERVE;
                    end
                end
                SERVE: begin
                    if (any_grant) begin
                        ack_d  = winner;
                        rand_d = lfsr_q;
                        lfsr_d = lfsr_stepped;
                        last_d = winner_idx;
                    end
                end
                default: begin
                    state_d = WARMUP;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= WARMUP;
            lfsr_q  <= SEED;
            rand_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            rand_q  <= rand_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.rand_o  = rand_q;
    assign bus.ready_o = (state_q == SERVE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter. Instance A runs with WARMUP_CYCLES=0 and
// carries most scenarios; instance B runs with WARMUP_CYCLES=32 and has its
// own reset for the warm-up scenario. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, after the edge settles.
module tb_lfsr_rng_arbiter;
    import lfsr_rng_pkg::*;

    localparam logic [31:0] SEED_C = 32'h00BC3328;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    fsm_state_e a_state;
    fsm_state_e b_state;

    int checks = 0;
    int errors = 0;

    // Reference model of instance A
    logic [31:0] m_lfsr;
    logic [31:0] m_rand;
    logic [3:0]  m_ack;
    int          m_last;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    lfsr_rng_arbiter_if #(.NUM_REQ(4)) a_if ();
    lfsr_rng_arbiter_if #(.NUM_REQ(4)) b_if ();

    lfsr_rng_arbiter #(
        .NUM_REQ       (4),
        .WARMUP_CYCLES (0),
        .SEED          (SEED_C)
    ) dut_a (
        .clk_i       (clk),
        .reset_i     (reset_a),
        .bus         (a_if),
        .dbg_state_o (a_state)
    );

    lfsr_rng_arbiter #(
        .NUM_REQ       (4),
        .WARMUP_CYCLES (32),
        .SEED          (SEED_C)
    ) dut_b (
        .clk_i       (clk),
        .reset_i     (reset_b),
        .bus         (b_if),
        .dbg_state_o (b_state)
    );

    // Next LFSR value straight from the tap list; a zero result falls back
    // to the seed so the sequence never locks up.
    function automatic logic [31:0] ref_next(input logic [31:0] s);
        int taps [9];
        logic fb;
        logic [31:0] n;
        taps = '{27, 23, 19, 18, 15, 11, 7, 4, 1};
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ s[taps[i]];
        n = {s[30:0], fb};
        if (n == 32'd0) n = SEED_C;
        return n;
    endfunction

    // Round-robin choice: first eligible index after the last winner.
    function automatic int rr_pick(input logic [3:0] elig, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (elig[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_lfsr = SEED_C;
        m_rand = 32'd0;
        m_ack  = 4'd0;
        m_last = 3;
    endfunction

    // One serving edge of instance A, predicted from the driven requests.
    task automatic serve_edge();
        logic [3:0] elig;
        int k;
        elig = a_if.req_i & ~m_ack;
        k = rr_pick(elig, m_last);
        @(posedge clk);
        #1;
        if (k >= 0) begin
            m_ack  = 4'(1 << k);
            m_rand = m_lfsr;
            m_lfsr = ref_next(m_lfsr);
            m_last = k;
        end else begin
            m_ack = 4'd0;
        end
    endtask

    task automatic test_reset();
        checks++; if (a_if.ack_o !== 4'd0) begin errors++; $display("FAIL reset_ack: got %b want 0000", a_if.ack_o); end
        checks++; if (a_if.rand_o !== 32'd0) begin errors++; $display("FAIL reset_rand: got %h want 00000000", a_if.rand_o); end
        checks++; if (a_if.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", a_if.ready_o); end
        checks++; if (a_state !== WARMUP) begin errors++; $display("FAIL reset_state: got %0d want WARMUP", a_state); end
        reset_a = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (a_if.ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_1_edge: got %b want 1", a_if.ready_o); end
        checks++; if (a_if.ack_o !== 4'd0) begin errors++; $display("FAIL no_ack_on_entry: got %b want 0000", a_if.ack_o); end
    endtask

    task automatic test_first_word();
        a_if.req_i = 4'b0001;
        serve_edge();
        checks++; if (a_if.ack_o !== 4'b0001) begin errors++; $display("FAIL first_ack: got %b want 0001", a_if.ack_o); end
        checks++; if (a_if.rand_o !== 32'h00BC3328) begin errors++; $display("FAIL first_word: got %h want 00bc3328", a_if.rand_o); end
        serve_edge();
        checks++; if (a_if.ack_o !== 4'b0000) begin errors++; $display("FAIL masked_cycle: got %b want 0000", a_if.ack_o); end
        serve_edge();
        checks++; if (a_if.ack_o !== 4'b0001) begin errors++; $display("FAIL second_ack: got %b want 0001", a_if.ack_o); end
        checks++; if (a_if.rand_o !== 32'h01786651) begin errors++; $display("FAIL second_word: got %h want 01786651", a_if.rand_o); end
        a_if.req_i = 4'b0000;
        serve_edge();
        checks++; if (a_if.ack_o !== 4'b0000) begin errors++; $display("FAIL idle_ack: got %b want 0000", a_if.ack_o); end
        checks++; if (a_if.rand_o !== 32'h01786651) begin errors++; $display("FAIL rand_hold: got %h want 01786651", a_if.rand_o); end
    endtask

    task automatic test_round_robin();
        logic [31:0] w;
        logic [31:0] word;
        int exp_idx;
        bit seen [logic [31:0]];
        w = m_lfsr;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(w);
            w = ref_next(w);
        end
        a_if.req_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_idx = (m_last + 1) % 4;
            serve_edge();
            word = exp_q.pop_front();
            checks++; if (a_if.ack_o !== 4'(1 << exp_idx)) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", i, a_if.ack_o, 4'(1 << exp_idx)); end
            checks++; if (a_if.rand_o !== word) begin errors++; $display("FAIL rr_word[%0d]: got %h want %h", i, a_if.rand_o, word); end
            checks++; if (seen.exists(a_if.rand_o)) begin errors++; $display("FAIL rr_unique[%0d]: got repeated %h want fresh word", i, a_if.rand_o); end
            seen[a_if.rand_o] = 1'b1;
        end
        a_if.req_i = 4'b0000;
        serve_edge();
    endtask

    task automatic test_back_to_back();
        a_if.req_i = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            serve_edge();
            checks++; if (a_if.ack_o !== ((i % 2 == 0) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, a_if.ack_o, (i % 2 == 0) ? 4'b0100 : 4'b0000); end
            checks++; if (a_if.rand_o !== m_rand) begin errors++; $display("FAIL b2b_word[%0d]: got %h want %h", i, a_if.rand_o, m_rand); end
        end
        a_if.req_i = 4'b0000;
        serve_edge();
    endtask

    task automatic test_random_traffic();
        logic [3:0] r;
        for (int c = 0; c < 80; c++) begin
            r = a_if.req_i;
            for (int k = 0; k < 4; k++) begin
                if (r[k] && m_ack[k]) begin
                    r[k] = ($urandom_range(0, 1) == 1);
                end else if (!r[k]) begin
                    r[k] = ($urandom_range(0, 2) == 0);
                end
            end
            a_if.req_i = r;
            serve_edge();
            checks++; if (a_if.ack_o !== m_ack) begin errors++; $display("FAIL rand_ack[%0d]: got %b want %b", c, a_if.ack_o, m_ack); end
            checks++; if (a_if.rand_o !== m_rand) begin errors++; $display("FAIL rand_word[%0d]: got %h want %h", c, a_if.rand_o, m_rand); end
        end
        a_if.req_i = 4'b0000;
        serve_edge();
    endtask

    task automatic test_reseed();
        a_if.req_i        = 4'b0010;
        a_if.seed_valid_i = 1'b1;
        a_if.seed_i       = 32'h00BC3328;
        @(posedge clk);
        #1;
        m_lfsr = 32'h00BC3328;
        m_ack  = 4'd0;
        a_if.seed_valid_i = 1'b0;
        a_if.seed_i       = 32'd0;
        checks++; if (a_if.ack_o !== 4'd0) begin errors++; $display("FAIL reseed_drop: got %b want 0000", a_if.ack_o); end
        checks++; if (a_if.ready_o !== 1'b0) begin errors++; $display("FAIL reseed_ready_low: got %b want 0", a_if.ready_o); end
        checks++; if (a_if.rand_o !== m_rand) begin errors++; $display("FAIL reseed_rand_hold: got %h want %h", a_if.rand_o, m_rand); end
        @(posedge clk);
        #1;
        checks++; if (a_if.ready_o !== 1'b1) begin errors++; $display("FAIL reseed_ready_back: got %b want 1", a_if.ready_o); end
        checks++; if (a_if.ack_o !== 4'd0) begin errors++; $display("FAIL reseed_warm_ack: got %b want 0000", a_if.ack_o); end
        serve_edge();
        checks++; if (a_if.ack_o !== 4'b0010) begin errors++; $display("FAIL reseed_served: got %b want 0010", a_if.ack_o); end
        checks++; if (a_if.rand_o !== 32'h00BC3328) begin errors++; $display("FAIL reseed_word: got %h want 00bc3328", a_if.rand_o); end
        a_if.req_i = 4'b0000;
        serve_edge();
    endtask

    task automatic test_zero_seed();
        a_if.seed_valid_i = 1'b1;
        a_if.seed_i       = 32'd0;
        @(posedge clk);
        #1;
        m_lfsr = SEED_C;
        m_ack  = 4'd0;
        a_if.seed_valid_i = 1'b0;
        checks++; if (a_if.ready_o !== 1'b0) begin errors++; $display("FAIL zero_seed_ready: got %b want 0", a_if.ready_o); end
        @(posedge clk);
        #1;
        a_if.req_i = 4'b1111;
        serve_edge();
        checks++; if (a_if.rand_o !== 32'h00BC3328) begin errors++; $display("FAIL zero_seed_word: got %h want 00bc3328", a_if.rand_o); end
        for (int i = 0; i < 12; i++) begin
            serve_edge();
            checks++; if (a_if.rand_o !== m_rand) begin errors++; $display("FAIL zero_seed_seq[%0d]: got %h want %h", i, a_if.rand_o, m_rand); end
            checks++; if (a_if.rand_o === 32'd0) begin errors++; $display("FAIL zero_seed_nonzero[%0d]: got %h want nonzero", i, a_if.rand_o); end
        end
    endtask

    task automatic test_async_reset();
        a_if.req_i = 4'b1111;
        serve_edge();
        checks++; if (a_if.ack_o !== m_ack || m_ack == 4'd0) begin errors++; $display("FAIL pre_reset_ack: got %b want %b", a_if.ack_o, m_ack); end
        #3;
        reset_a = 1'b1;
        #1;
        checks++; if (a_if.ack_o !== 4'd0) begin errors++; $display("FAIL async_ack: got %b want 0000", a_if.ack_o); end
        checks++; if (a_if.rand_o !== 32'd0) begin errors++; $display("FAIL async_rand: got %h want 00000000", a_if.rand_o); end
        checks++; if (a_if.ready_o !== 1'b0) begin errors++; $display("FAIL async_ready: got %b want 0", a_if.ready_o); end
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        serve_edge();
        checks++; if (a_if.ack_o !== 4'b0001) begin errors++; $display("FAIL post_reset_ack: got %b want 0001", a_if.ack_o); end
        checks++; if (a_if.rand_o !== 32'h00BC3328) begin errors++; $display("FAIL post_reset_word: got %h want 00bc3328", a_if.rand_o); end
        a_if.req_i = 4'b0000;
        serve_edge();
    endtask

    task automatic test_warmup();
        logic [31:0] w;
        w = SEED_C;
        for (int i = 0; i < 32; i++) w = ref_next(w);
        reset_b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            checks++; if (b_if.ack_o !== 4'd0 || b_if.ready_o !== 1'b0) begin errors++; $display("FAIL warmup_quiet[%0d]: got ack %b ready %b want 0000 0", i, b_if.ack_o, b_if.ready_o); end
        end
        @(posedge clk);
        #1;
        checks++; if (b_if.ready_o !== 1'b1) begin errors++; $display("FAIL warmup_ready: got %b want 1", b_if.ready_o); end
        @(posedge clk);
        #1;
        checks++; if (b_if.ack_o !== 4'b0001) begin errors++; $display("FAIL warmup_first_ack: got %b want 0001", b_if.ack_o); end
        checks++; if (b_if.rand_o !== w) begin errors++; $display("FAIL warmup_first_word: got %h want %h", b_if.rand_o, w); end
        @(posedge clk);
        #1;
        checks++; if (b_if.ack_o !== 4'b0010) begin errors++; $display("FAIL warmup_second_ack: got %b want 0010", b_if.ack_o); end
        checks++; if (b_if.rand_o !== ref_next(w)) begin errors++; $display("FAIL warmup_second_word: got %h want %h", b_if.rand_o, ref_next(w)); end
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        a_if.req_i        = 4'd0;
        a_if.seed_valid_i = 1'b0;
        a_if.seed_i       = 32'd0;
        b_if.req_i        = 4'b1111;
        b_if.seed_valid_i = 1'b0;
        b_if.seed_i       = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_first_word();
        test_round_robin();
        test_back_to_back();
        test_random_traffic();
        test_reseed();
        test_zero_seed();
        test_async_reset();
        test_warmup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
